// File: rtl/uart_tx_fifo_pkg.sv
// Shared types for the FIFO-buffered UART transmitter.
//   parity_t   : runtime parity selection (PAR_RSVD behaves as PAR_NONE)
//   tx_state_t : transmitter frame sequencer states
//   par_enabled: true when the selected mode inserts a parity bit
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic logic par_enabled(parity_t mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO holding words queued for transmission.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers and count)
//   push       : write wr_data; ignored while full (even if pop is also high)
//   pop        : advance the read pointer; ignored while empty
//   wr_data    : word to enqueue
//   rd_data    : head-of-queue word (valid while !empty)
//   full/empty : registered count decodes
//   count      : number of queued entries
module uart_tx_fifo_sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  logic [W-1:0]    mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            push_ok, pop_ok;

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];

  // A push while full is dropped even when a pop frees a slot in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wr_data;
  end

  // Pointers are exactly PtrW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a TX FIFO and per-frame runtime format.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   baud_div    : bit period = baud_div+1 clocks (sampled when a frame starts)
//   parity_mode : 00 none, 01 even, 10 odd, 11 none (sampled when a frame starts)
//   two_stop    : 0 one stop bit, 1 two stop bits (sampled when a frame starts)
//   wr_en       : push wr_data into the FIFO
//   wr_data     : word to transmit, LSB first
//   full        : FIFO full, pushes are dropped
//   ovf         : wr_en while full (the word is lost this cycle)
//   fifo_cnt    : queued entries
//   TX          : serial line, idle high
//   tx_done     : FSM idle with nothing queued
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BAUD_W     = 13
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BAUD_W-1:0]             baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          full,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          TX,
  output logic                          tx_done
);

  localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);

  tx_state_t         state_q;
  logic [BAUD_W-1:0] baud_q, div_q;
  logic [BitW-1:0]   bit_q;
  logic [DATA_W-1:0] sh_q;
  logic              tx_q, done_q, par_en_q, par_q, stop2_q;

  logic              empty, pop, tick;
  logic [DATA_W-1:0] rd_data;
  parity_t           mode;

  assign mode    = parity_t'(parity_mode);
  assign pop     = (state_q == IDLE) && !empty;
  assign tick    = (baud_q == '0);
  assign ovf     = wr_en && full;
  assign TX      = tx_q;
  assign tx_done = done_q;

  uart_tx_fifo_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (wr_en),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tx_q     <= 1'b1;
      done_q   <= 1'b1;
      baud_q   <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
    end else begin
      // Bit timer: reload at every boundary so each bit is exactly div_q+1 clocks.
      if (state_q != IDLE) baud_q <= tick ? div_q : baud_q - 1'b1;

      case (state_q)
        IDLE: begin
          if (pop) begin
            // Frame format is frozen here; later config changes wait for the next frame.
            state_q  <= START;
            tx_q     <= 1'b0;
            done_q   <= 1'b0;
            baud_q   <= baud_div;
            div_q    <= baud_div;
            sh_q     <= rd_data;
            par_en_q <= par_enabled(mode);
            par_q    <= (mode == PAR_ODD) ? ~^rd_data : ^rd_data;
            stop2_q  <= two_stop;
          end else begin
            done_q <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state_q <= DATA;
            tx_q    <= sh_q[0];
            sh_q    <= sh_q >> 1;
            bit_q   <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_q == LastBit) begin
              state_q <= par_en_q ? PARITY : STOP;
              tx_q    <= par_en_q ? par_q : 1'b1;
            end else begin
              tx_q  <= sh_q[0];
              sh_q  <= sh_q >> 1;
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop2_q) begin
              stop2_q <= 1'b0;
            end else begin
              state_q <= IDLE;
              done_q  <= empty;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] baud_div = 13'd433;
  logic [1:0]  parity_mode = 2'b00;
  logic        two_stop = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        full, ovf, tx8, tx_done;
  logic [4:0]  fifo_cnt;

  logic        wr_en5 = 1'b0;
  logic [4:0]  wr_data5 = 5'h00;
  logic        full5, ovf5, tx5, tx_done5;
  logic [4:0]  fifo_cnt5;

  int total = 0;
  int bad = 0;
  int ovf_seen = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(16), .BAUD_W(13)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .ovf         (ovf),
    .fifo_cnt    (fifo_cnt),
    .TX          (tx8),
    .tx_done     (tx_done)
  );

  uart_tx_fifo #(.DATA_W(5), .FIFO_DEPTH(16), .BAUD_W(13)) u_dut5 (
    .clk         (clk),
    .rst_n       (rst_n),
    .baud_div    (13'd1),
    .parity_mode (2'b10),
    .two_stop    (1'b1),
    .wr_en       (wr_en5),
    .wr_data     (wr_data5),
    .full        (full5),
    .ovf         (ovf5),
    .fifo_cnt    (fifo_cnt5),
    .TX          (tx5),
    .tx_done     (tx_done5)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Line-level model: a queue of words, and a queue of expected TX samples (one per clock).
  logic [7:0] mq[$];
  bit         lq[$];
  bit         m_tx = 1'b1;
  bit         m_done = 1'b1;

  task automatic build_frame(input logic [7:0] d, input int div, input logic [1:0] pm,
                             input bit ts);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pm == 2'b01) bits.push_back(^d);
    if (pm == 2'b10) bits.push_back(~^d);
    bits.push_back(1'b1);
    if (ts) bits.push_back(1'b1);
    foreach (bits[k]) repeat (div + 1) lq.push_back(bits[k]);
    lq.push_back(1'b1);  // clock on which the transmitter returns to idle
  endtask

  always @(posedge clk or negedge rst_n) begin
    int cnt;
    if (!rst_n) begin
      mq.delete();
      lq.delete();
      m_tx = 1'b1;
      m_done = 1'b1;
    end else begin
      cnt = mq.size();
      if (lq.size() != 0) begin
        m_tx = lq.pop_front();
        m_done = (lq.size() == 0) ? (cnt == 0) : 1'b0;
      end else if (cnt != 0) begin
        build_frame(mq.pop_front(), int'(baud_div), parity_mode, two_stop);
        m_tx = lq.pop_front();
        m_done = 1'b0;
      end else begin
        m_tx = 1'b1;
        m_done = 1'b1;
      end
      if (wr_en && cnt < 16) mq.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    chk("model TX", tx8, m_tx);
    chk("model tx_done", tx_done, m_done);
    chk("model fifo_cnt", fifo_cnt, mq.size());
    chk("model full", full, mq.size() == 16);
    chk("model ovf", ovf, wr_en && (mq.size() == 16));
    if (ovf) ovf_seen++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Finds the start bit, then samples each bit mid-period and the tx_done rise.
  task automatic check_frame(input string nm, input bit sel, input logic [15:0] bits,
                             input int n, input int div);
    int off, tgt, waited;
    bit fell;
    fell = 1'b0;
    waited = 0;
    while (!fell && waited < 40) begin
      @(negedge clk);
      waited++;
      if ((sel ? tx5 : tx8) == 1'b0) fell = 1'b1;
    end
    chk({nm, " start seen"}, fell, 1'b1);
    if (!fell) return;
    off = 0;
    for (int i = 0; i < n; i++) begin
      tgt = i * (div + 1) + (div + 1) / 2;
      while (off < tgt) begin @(negedge clk); off++; end
      chk($sformatf("%s bit%0d", nm, i), sel ? tx5 : tx8, bits[i]);
    end
    tgt = n * (div + 1) - 1;
    while (off < tgt) begin @(negedge clk); off++; end
    chk({nm, " tx_done low in last stop clock"}, sel ? tx_done5 : tx_done, 1'b0);
    @(negedge clk);
    chk({nm, " tx_done rise"}, sel ? tx_done5 : tx_done, 1'b1);
  endtask

  task automatic wait_done(input string nm, input int bound);
    int waited;
    waited = 0;
    while (!tx_done && waited < bound) begin @(negedge clk); waited++; end
    chk({nm, " tx_done within bound"}, tx_done, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, lows;
    repeat (3) @(negedge clk);
    chk("reset TX", tx8, 1'b1);
    chk("reset full", full, 1'b0);
    chk("reset ovf", ovf, 1'b0);
    chk("reset fifo_cnt", fifo_cnt, 5'd0);
    chk("reset tx_done", tx_done, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // 8N1, A5 -> 0,1,0,1,0,0,1,0,1,1
    push(8'hA5);
    check_frame("8N1 A5", 1'b0, 16'b0000_0011_0100_1010, 10, 433);

    // 8E2, 07 -> parity 1, two stop bits
    parity_mode = 2'b01;
    two_stop = 1'b1;
    push(8'h07);
    check_frame("8E2 07", 1'b0, 16'b0000_1110_0000_1110, 12, 433);

    // 8O1, 07 -> parity 0
    parity_mode = 2'b10;
    two_stop = 1'b0;
    push(8'h07);
    check_frame("8O1 07", 1'b0, 16'b0000_0100_0000_1110, 11, 433);

    // Burst of 18: the 17th fits because one word was popped, the 18th overflows.
    parity_mode = 2'b00;
    baud_div = 13'd3;
    base = ovf_seen;
    for (int i = 0; i < 18; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      if (i == 17) begin
        @(negedge clk);
        chk("burst full", full, 1'b1);
        chk("burst fifo_cnt", fifo_cnt, 5'd16);
        chk("burst ovf", ovf, 1'b1);
      end
      step();
    end
    wr_en = 1'b0;
    wait_done("burst", 2000);
    chk("burst ovf pulses", ovf_seen - base, 1);

    // Config change mid-frame: frame 1 keeps one stop bit, frame 2 gets two.
    two_stop = 1'b0;
    push(8'h3C);
    push(8'hC3);
    check_cfg : begin
      int off;
      bit fell;
      fell = 1'b0;
      off = 0;
      while (!fell && off < 40) begin
        @(negedge clk);
        off++;
        if (!tx8) fell = 1'b1;
      end
      chk("cfg start seen", fell, 1'b1);
      repeat (5) @(negedge clk);
      two_stop = 1'b1;
      repeat (35) @(negedge clk);
      chk("cfg frame1 idle clock", tx8, 1'b1);
      @(negedge clk);
      chk("cfg frame2 start", tx8, 1'b0);
      repeat (43) @(negedge clk);
      chk("cfg frame2 still in stop", tx_done, 1'b0);
      @(negedge clk);
      chk("cfg frame2 done", tx_done, 1'b1);
    end
    two_stop = 1'b0;

    // Reset during DATA with three words queued.
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    repeat (10) @(negedge clk);
    chk("pre-reset fifo_cnt", fifo_cnt, 5'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset TX", tx8, 1'b1);
    chk("async reset fifo_cnt", fifo_cnt, 5'd0);
    chk("async reset tx_done", tx_done, 1'b1);
    chk("async reset full", full, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (!tx8) lows++;
    end
    chk("no resume after reset", lows, 0);
    chk("post-reset tx_done", tx_done, 1'b1);

    // DATA_W=5, odd parity, two stop bits, baud_div=1.
    step();
    wr_en5 = 1'b1;
    wr_data5 = 5'h1B;
    step();
    wr_en5 = 1'b0;
    check_frame("5O2 1B", 1'b1, 16'b0000_0001_1111_0110, 9, 1);
    chk("w5 fifo_cnt", fifo_cnt5, 5'd0);
    chk("w5 full", full5, 1'b0);
    chk("w5 ovf", ovf5, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
